// File: rtl/usb_xfer_ctrl_if.sv
// Bundle between the endpoint sequencer and its surroundings: RX/TX cores,
// shared data buffer and the AHB register file.
interface usb_xfer_ctrl_if #(
  parameter int BUF_DEPTH = 64
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic          rx_pkt_valid;
  logic [2:0]    rx_pid;
  logic          rx_active;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] tx_size;
  logic          tx_armed;
  logic          tx_busy;
  logic          tx_start;
  logic [2:0]    tx_pid;
  logic          buf_owner_rx;
  logic          buf_flush;
  logic          rx_done;
  logic          tx_done;
  logic          xfer_err;
  logic          clr_status;

  modport slave (
    input  rx_pkt_valid, rx_pid, rx_active, buf_count, tx_size, tx_armed,
           tx_busy, clr_status,
    output tx_start, tx_pid, buf_owner_rx, buf_flush, rx_done, tx_done, xfer_err
  );

  modport master (
    output rx_pkt_valid, rx_pid, rx_active, buf_count, tx_size, tx_armed,
           tx_busy, clr_status,
    input  tx_start, tx_pid, buf_owner_rx, buf_flush, rx_done, tx_done, xfer_err
  );
endinterface

// File: rtl/usb_xfer_ctrl.sv
// Endpoint transaction sequencer: decodes host tokens, picks the handshake or
// data response, owns the shared buffer and tracks DATA0/DATA1 toggles.
module usb_xfer_ctrl #(
  parameter int BUF_DEPTH   = 64,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  usb_xfer_ctrl_if.slave  bus
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [TW-1:0] TMO_C   = TW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    PID_NONE, PID_OUT, PID_IN, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_BAD
  } rx_pid_e;

  typedef enum logic [2:0] {
    TXP_NONE  = 3'd0,
    TXP_DATA0 = 3'd1,
    TXP_DATA1 = 3'd2,
    TXP_ACK   = 3'd3,
    TXP_NAK   = 3'd4
  } tx_pid_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RX_DATA, ST_RX_ACK, ST_TX_DECIDE, ST_TX_SEND, ST_TX_WAIT_ACK,
    ST_NAK_SEND
  } state_e;

  state_e        r_state;
  logic          r_toggle_in;
  logic          r_toggle_out;
  logic [TW-1:0] r_cnt;
  logic          r_sent;
  logic          r_busy_q;
  logic          r_tx_start;
  logic [2:0]    r_tx_pid;
  logic          r_buf_owner_rx;
  logic          r_buf_flush;
  logic          r_rx_done;
  logic          r_tx_done;
  logic          r_xfer_err;

  logic          w_is_data;
  logic          w_tog_match;
  logic          w_busy_fall;
  logic [2:0]    w_send_pid;

  assign w_is_data   = (bus.rx_pid == PID_DATA0) || (bus.rx_pid == PID_DATA1);
  assign w_tog_match = (bus.rx_pid == PID_DATA1) == r_toggle_in;
  assign w_busy_fall = r_busy_q && !bus.tx_busy;

  always_comb begin
    w_send_pid = TXP_NONE;
    case (r_state)
      ST_RX_ACK:   w_send_pid = TXP_ACK;
      ST_NAK_SEND: w_send_pid = TXP_NAK;
      default:     w_send_pid = r_toggle_out ? TXP_DATA1 : TXP_DATA0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_toggle_in    <= 1'b0;
      r_toggle_out   <= 1'b0;
      r_cnt          <= '0;
      r_sent         <= 1'b0;
      r_busy_q       <= 1'b0;
      r_tx_start     <= 1'b0;
      r_tx_pid       <= '0;
      r_buf_owner_rx <= 1'b0;
      r_buf_flush    <= 1'b0;
      r_rx_done      <= 1'b0;
      r_tx_done      <= 1'b0;
      r_xfer_err     <= 1'b0;
    end else begin
      r_tx_start  <= 1'b0;
      r_buf_flush <= 1'b0;
      r_busy_q    <= bus.tx_busy;
      // Clear first so any set event later in this block takes priority.
      if (bus.clr_status) begin
        r_rx_done  <= 1'b0;
        r_tx_done  <= 1'b0;
        r_xfer_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.rx_pkt_valid) begin
            case (bus.rx_pid)
              PID_OUT: begin
                r_state        <= ST_RX_DATA;
                r_buf_owner_rx <= 1'b1;
              end
              PID_IN:  r_state    <= ST_TX_DECIDE;
              PID_BAD: r_xfer_err <= 1'b1;
              default: ;
            endcase
          end
        end

        ST_RX_DATA: begin
          if (bus.rx_pkt_valid) begin
            r_buf_owner_rx <= 1'b0;
            if (w_is_data && !w_tog_match) begin
              // Host retransmit of data already accepted: drop it, still ACK.
              r_buf_flush <= 1'b1;
              r_state     <= ST_RX_ACK;
            end else if (w_is_data && bus.buf_count <= DEPTH_C) begin
              r_toggle_in <= ~r_toggle_in;
              r_rx_done   <= 1'b1;
              r_state     <= ST_RX_ACK;
            end else begin
              r_xfer_err  <= 1'b1;
              r_buf_flush <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end

        ST_TX_DECIDE: begin
          if (bus.tx_armed && bus.buf_count >= bus.tx_size) r_state <= ST_TX_SEND;
          else                                              r_state <= ST_NAK_SEND;
        end

        // All three share one start/complete handshake with the TX core.
        ST_RX_ACK, ST_TX_SEND, ST_NAK_SEND: begin
          if (!r_sent) begin
            if (!bus.tx_busy) begin
              r_tx_start <= 1'b1;
              r_tx_pid   <= w_send_pid;
              r_sent     <= 1'b1;
            end
          end else if (w_busy_fall) begin
            r_sent  <= 1'b0;
            r_cnt   <= '0;
            r_state <= (r_state == ST_TX_SEND) ? ST_TX_WAIT_ACK : ST_IDLE;
          end
        end

        ST_TX_WAIT_ACK: begin
          if (bus.rx_pkt_valid) begin
            r_state <= ST_IDLE;
            if (bus.rx_pid == PID_ACK) begin
              r_tx_done    <= 1'b1;
              r_toggle_out <= ~r_toggle_out;
            end else begin
              r_xfer_err <= 1'b1;
            end
          end else if (r_cnt == TMO_C) begin
            r_xfer_err <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (!bus.rx_active) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_start     = r_tx_start;
  assign bus.tx_pid       = r_tx_pid;
  assign bus.buf_owner_rx = r_buf_owner_rx;
  assign bus.buf_flush    = r_buf_flush;
  assign bus.rx_done      = r_rx_done;
  assign bus.tx_done      = r_tx_done;
  assign bus.xfer_err     = r_xfer_err;
endmodule

// File: tb/tb_usb_xfer_ctrl.sv
// Self-checking bench for usb_xfer_ctrl: expected TX PIDs are queued when
// tokens are driven and popped on every tx_start; flags checked directly.
module tb_usb_xfer_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_xfer_ctrl_if #(.BUF_DEPTH(64)) ifc ();

  usb_xfer_ctrl #(.BUF_DEPTH(64), .ACK_TIMEOUT(1023)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int         n_chk = 0;
  int         n_bad = 0;
  int         n_flush = 0;
  int         bcnt = 0;
  int         f0;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard pop on each transmitted packet; also counts buffer flushes.
  always @(negedge clk) begin
    if (ifc.buf_flush) n_flush++;
    if (ifc.tx_start) begin
      if (exp_q.size() == 0) chk("unexpected_tx_start", 32'(ifc.tx_pid), 32'(0));
      else                   chk("tx_pid", 32'(ifc.tx_pid), 32'(exp_q.pop_front()));
    end
  end

  // TX core model: busy for 4 cycles after each start.
  initial begin
    ifc.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ifc.tx_start) bcnt = 4;
      else if (bcnt > 0) bcnt--;
      ifc.tx_busy = (bcnt != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_pkt(input logic [2:0] pid, input logic clr = 1'b0);
    @(posedge clk); #1;
    ifc.rx_pkt_valid = 1'b1;
    ifc.rx_pid       = pid;
    ifc.clr_status   = clr;
    @(posedge clk); #1;
    ifc.rx_pkt_valid = 1'b0;
    ifc.rx_pid       = 3'd0;
    ifc.clr_status   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1;
    ifc.clr_status = 1'b1;
    @(posedge clk); #1;
    ifc.clr_status = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_start"}, 32'(ifc.tx_start), 32'(0));
    chk({tag, "_tx_pid"},   32'(ifc.tx_pid), 32'(0));
    chk({tag, "_owner"},    32'(ifc.buf_owner_rx), 32'(0));
    chk({tag, "_flush"},    32'(ifc.buf_flush), 32'(0));
    chk({tag, "_rx_done"},  32'(ifc.rx_done), 32'(0));
    chk({tag, "_tx_done"},  32'(ifc.tx_done), 32'(0));
    chk({tag, "_xfer_err"}, 32'(ifc.xfer_err), 32'(0));
  endtask

  // Full IN/DATA/ACK exchange; expected DATA PID supplied by caller.
  task automatic in_ack(input logic [2:0] exp_pid, input string tag);
    exp_q.push_back(exp_pid);
    send_pkt(3'd2);
    idle(12);
    chk({tag, "_tx_done_pre"}, 32'(ifc.tx_done), 32'(0));
    send_pkt(3'd5);
    chk({tag, "_tx_done"}, 32'(ifc.tx_done), 32'(1));
  endtask

  initial begin
    rst = 1'b1;
    ifc.rx_pkt_valid = 1'b0;
    ifc.rx_pid       = 3'd0;
    ifc.rx_active    = 1'b0;
    ifc.buf_count    = 7'd0;
    ifc.tx_size      = 7'd0;
    ifc.tx_armed     = 1'b0;
    ifc.clr_status   = 1'b0;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;

    // OUT + DATA0, valid data
    ifc.buf_count = 7'd8;
    send_pkt(3'd1);
    chk("owner_after_out", 32'(ifc.buf_owner_rx), 32'(1));
    exp_q.push_back(3'd3);
    send_pkt(3'd3);
    idle(12);
    chk("t1_rx_done", 32'(ifc.rx_done), 32'(1));
    chk("t1_err", 32'(ifc.xfer_err), 32'(0));
    chk("t1_owner", 32'(ifc.buf_owner_rx), 32'(0));

    // Retransmitted DATA0: flushed, ACKed, rx_done untouched
    clr_pulse();
    chk("clr_rx_done", 32'(ifc.rx_done), 32'(0));
    f0 = n_flush;
    send_pkt(3'd1);
    exp_q.push_back(3'd3);
    send_pkt(3'd3);
    idle(12);
    chk("t2_rx_done", 32'(ifc.rx_done), 32'(0));
    chk("t2_flush", 32'(n_flush - f0), 32'(1));
    send_pkt(3'd1);
    exp_q.push_back(3'd3);
    send_pkt(3'd4);
    idle(12);
    chk("t2_data1_rx_done", 32'(ifc.rx_done), 32'(1));

    // IDLE PID handling: bad PID errors, stray NAK ignored
    clr_pulse();
    send_pkt(3'd7);
    chk("idle_bad_pid", 32'(ifc.xfer_err), 32'(1));
    clr_pulse();
    send_pkt(3'd6);
    chk("idle_nak_ignored", 32'(ifc.xfer_err), 32'(0));

    // Overflow (65 > 64): error, flush, no handshake
    ifc.buf_count = 7'd65;
    f0 = n_flush;
    send_pkt(3'd1);
    send_pkt(3'd3);
    idle(12);
    chk("ovf_err", 32'(ifc.xfer_err), 32'(1));
    chk("ovf_rx_done", 32'(ifc.rx_done), 32'(0));
    chk("ovf_flush", 32'(n_flush - f0), 32'(1));
    chk("ovf_owner", 32'(ifc.buf_owner_rx), 32'(0));

    // Exactly full buffer is accepted
    clr_pulse();
    ifc.buf_count = 7'd64;
    send_pkt(3'd1);
    exp_q.push_back(3'd3);
    send_pkt(3'd3);
    idle(12);
    chk("full_rx_done", 32'(ifc.rx_done), 32'(1));
    chk("full_err", 32'(ifc.xfer_err), 32'(0));

    // IN: DATA0 then DATA1 after host ACK
    clr_pulse();
    ifc.tx_armed  = 1'b1;
    ifc.tx_size   = 7'd16;
    ifc.buf_count = 7'd16;
    in_ack(3'd1, "in0");
    clr_pulse();
    in_ack(3'd2, "in1");

    // NAK cases: not armed, and staged size above buffer count
    clr_pulse();
    ifc.tx_armed = 1'b0;
    exp_q.push_back(3'd4);
    send_pkt(3'd2);
    idle(12);
    chk("nak_err", 32'(ifc.xfer_err), 32'(0));
    chk("nak_tx_done", 32'(ifc.tx_done), 32'(0));
    chk("nak_rx_done", 32'(ifc.rx_done), 32'(0));
    ifc.tx_armed = 1'b1;
    ifc.tx_size  = 7'd17;
    exp_q.push_back(3'd4);
    send_pkt(3'd2);
    idle(12);
    chk("nak_short_tx_done", 32'(ifc.tx_done), 32'(0));

    // Zero-length DATA packet
    ifc.tx_size   = 7'd0;
    ifc.buf_count = 7'd0;
    in_ack(3'd1, "zlp");

    // Timeout without ACK, then retry with same DATA PID
    clr_pulse();
    ifc.tx_size   = 7'd16;
    ifc.buf_count = 7'd16;
    exp_q.push_back(3'd2);
    send_pkt(3'd2);
    idle(1000);
    chk("tmo_early", 32'(ifc.xfer_err), 32'(0));
    idle(60);
    chk("tmo_err", 32'(ifc.xfer_err), 32'(1));
    chk("tmo_tx_done", 32'(ifc.tx_done), 32'(0));
    clr_pulse();
    in_ack(3'd2, "retry");
    chk("retry_err", 32'(ifc.xfer_err), 32'(0));

    // Wrong handshake PID after DATA: error, toggle kept
    exp_q.push_back(3'd1);
    send_pkt(3'd2);
    idle(12);
    send_pkt(3'd6);
    chk("wrong_hs_err", 32'(ifc.xfer_err), 32'(1));
    clr_pulse();
    in_ack(3'd1, "wrong_hs_retry");

    // Async reset while waiting for ACK
    exp_q.push_back(3'd2);
    send_pkt(3'd2);
    idle(12);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    idle(2);
    rst = 1'b0;
    chk("rst_q_empty", 32'(exp_q.size()), 32'(0));
    in_ack(3'd1, "post_rst");

    // Set beats coincident clear; then clear drops all sticky flags
    send_pkt(3'd7, 1'b1);
    chk("set_wins_err", 32'(ifc.xfer_err), 32'(1));
    chk("set_wins_tx_done", 32'(ifc.tx_done), 32'(0));
    ifc.buf_count = 7'd8;
    send_pkt(3'd1);
    exp_q.push_back(3'd3);
    send_pkt(3'd3);
    idle(12);
    chk("pre_clr_rx_done", 32'(ifc.rx_done), 32'(1));
    clr_pulse();
    chk("clr_rx", 32'(ifc.rx_done), 32'(0));
    chk("clr_tx", 32'(ifc.tx_done), 32'(0));
    chk("clr_err", 32'(ifc.xfer_err), 32'(0));

    idle(4);
    chk("final_q_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
